alu_sched: RTL and testbench

Shared-ALU scheduler for the Y86-64 execute stage. It arbitrates two requesters onto the single combinational `alu_` instance: requester 0 is the OPq/integer path and requester 1 is the address/stack-pointer adder. It issues at most one operation per cycle and registers the result in a one-entry response buffer with valid/ready backpressure. It also owns the architectural condition-code register (ZF, SF, OF).

---
 rtl/alu_sched.sv | 197 +++++++++++++++++++
 tb/tb_alu_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Shared-ALU scheduler for the Y86-64 execute stage.
// Two requesters share one combinational ALU through a round-robin arbiter.
// Results sit in a one-entry response buffer with valid/ready backpressure.
// The architectural condition codes {ZF,SF,OF} are also held here.

module alu_ (
    input  logic [63:0] inp1,
    input  logic [63:0] inp2,
    input  logic [1:0]  op,
    output logic [63:0] out,
    output logic [2:0]  cc_out
);
    logic of_s;

    // Combinational ALU: 00 add, 01 sub (inp1-inp2), 10 and, 11 xor, plus {ZF,SF,OF}
    always_comb begin
        out  = 64'd0;
        of_s = 1'b0;
        case (op)
            2'b00: begin
                out  = inp1 + inp2;
                of_s = (inp1[63] == inp2[63]) && (out[63] != inp1[63]);
            end
            2'b01: begin
                out  = inp1 - inp2;
                of_s = (inp1[63] != inp2[63]) && (out[63] != inp1[63]);
            end
            2'b10: begin
                out  = inp1 & inp2;
                of_s = 1'b0;
            end
            2'b11: begin
                out  = inp1 ^ inp2;
                of_s = 1'b0;
            end
            default: begin
                out  = 64'd0;
                of_s = 1'b0;
            end
        endcase
        cc_out = {(out == 64'd0), out[63], of_s};
    end
endmodule

module alu_sched #(
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req0_setcc,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic [1:0]  req1_op,
    input  logic        req1_setcc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_val,
    output logic [2:0]  rsp_cc,
    output logic [2:0]  cc
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        rsp_id_q, rsp_id_d;
    logic [63:0] rsp_val_q, rsp_val_d;
    logic [2:0]  rsp_cc_q, rsp_cc_d;
    logic [2:0]  cc_q, cc_d;

    logic        slot_free_s;
    logic        grant_s;
    logic        fire_s;
    logic [63:0] alu_a_s;
    logic [63:0] alu_b_s;
    logic [1:0]  alu_op_s;
    logic        setcc_s;
    logic [63:0] alu_out_s;
    logic [2:0]  alu_cc_s;

    alu_ u_alu (
        .inp1   (alu_a_s),
        .inp2   (alu_b_s),
        .op     (alu_op_s),
        .out    (alu_out_s),
        .cc_out (alu_cc_s)
    );

    // Arbitration, operand steering and next-state computation for all flops
    always_comb begin
        slot_free_s = (state_q == ST_EMPTY) || rsp_ready;

        if (req0_valid && req1_valid) begin
            grant_s = prio_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end

        // Requests seen during reset are never accepted
        fire_s     = !rst && slot_free_s && (req0_valid || req1_valid);
        req0_ready = fire_s && !grant_s && req0_valid;
        req1_ready = fire_s &&  grant_s && req1_valid;

        if (grant_s) begin
            alu_a_s  = req1_a;
            alu_b_s  = req1_b;
            alu_op_s = req1_op;
            setcc_s  = req1_setcc;
        end else begin
            alu_a_s  = req0_a;
            alu_b_s  = req0_b;
            alu_op_s = req0_op;
            setcc_s  = req0_setcc;
        end

        state_d   = state_q;
        prio_d    = prio_q;
        rsp_id_d  = rsp_id_q;
        rsp_val_d = rsp_val_q;
        rsp_cc_d  = rsp_cc_q;
        cc_d      = cc_q;

        if (fire_s) begin
            rsp_id_d  = grant_s;
            rsp_val_d = alu_out_s;
            rsp_cc_d  = alu_cc_s;
            prio_d    = !grant_s;
            if (setcc_s) begin
                cc_d = alu_cc_s;
            end else begin
                cc_d = cc_q;
            end
        end else begin
            rsp_id_d  = rsp_id_q;
            rsp_val_d = rsp_val_q;
            rsp_cc_d  = rsp_cc_q;
        end

        case (state_q)
            ST_EMPTY: begin
                if (fire_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rsp_ready && !fire_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State, response buffer and condition-code registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            prio_q    <= 1'b0;
            rsp_id_q  <= 1'b0;
            rsp_val_q <= 64'd0;
            rsp_cc_q  <= 3'b000;
            cc_q      <= CC_RESET;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            rsp_id_q  <= rsp_id_d;
            rsp_val_q <= rsp_val_d;
            rsp_cc_q  <= rsp_cc_d;
            cc_q      <= cc_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_val   = rsp_val_q;
    assign rsp_cc    = rsp_cc_q;
    assign cc        = cc_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios plus randomized traffic,
// compared against a transaction-level reference model of the scheduler.

module tb_alu_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        req0_setcc, req1_setcc;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [63:0] rsp_val;
    logic [2:0]  rsp_cc, cc;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    bit          m_valid = 1'b0;
    bit          m_id    = 1'b0;
    bit [63:0]   m_val   = 64'd0;
    bit [2:0]    m_rcc   = 3'b000;
    bit [2:0]    m_cc    = 3'b100;
    bit          m_prio  = 1'b0;

    alu_sched #(.CC_RESET(3'b100)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_setcc(req0_setcc),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_setcc(req1_setcc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_val(rsp_val), .rsp_cc(rsp_cc), .cc(cc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // arithmetic reference: signed results computed one bit wider
    task automatic ref_alu(input bit [63:0] a, input bit [63:0] b, input bit [1:0] op,
                           output bit [63:0] val, output bit [2:0] flags);
        bit [64:0] wide;
        bit        of;
        of = 1'b0;
        case (op)
            2'b00: begin wide = {a[63], a} + {b[63], b}; val = wide[63:0]; of = wide[64] != wide[63]; end
            2'b01: begin wide = {a[63], a} - {b[63], b}; val = wide[63:0]; of = wide[64] != wide[63]; end
            2'b10: val = a & b;
            default: val = a ^ b;
        endcase
        flags = {(val == 64'd0), val[63], of};
    endtask

    // one clock cycle: check readies, advance model, check registered outputs
    task automatic tick();
        bit slot, any, g, fire, e0, e1, sc;
        bit [63:0] v;
        bit [2:0]  f;
        #1;
        slot = !m_valid || rsp_ready;
        any  = req0_valid || req1_valid;
        g    = (req0_valid && req1_valid) ? m_prio : req1_valid;
        fire = !rst && slot && any;
        e0   = fire && (g == 1'b0);
        e1   = fire && (g == 1'b1);
        check_val("req0_ready", {63'd0, req0_ready}, {63'd0, e0});
        check_val("req1_ready", {63'd0, req1_ready}, {63'd0, e1});
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_id = 1'b0; m_val = 64'd0; m_rcc = 3'b000;
            m_cc = 3'b100; m_prio = 1'b0;
        end else if (fire) begin
            if (g) begin ref_alu(req1_a, req1_b, req1_op, v, f); sc = req1_setcc; end
            else   begin ref_alu(req0_a, req0_b, req0_op, v, f); sc = req0_setcc; end
            m_valid = 1'b1; m_id = g; m_val = v; m_rcc = f; m_prio = !g;
            if (sc) m_cc = f;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_val("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
        check_val("rsp_id",    {63'd0, rsp_id},    {63'd0, m_id});
        check_val("rsp_val",   rsp_val, m_val);
        check_val("rsp_cc",    {61'd0, rsp_cc},    {61'd0, m_rcc});
        check_val("cc",        {61'd0, cc},        {61'd0, m_cc});
    endtask

    task automatic set0(input bit v, input bit [63:0] a, input bit [63:0] b, input bit [1:0] op, input bit sc);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_setcc = sc;
    endtask

    task automatic set1(input bit v, input bit [63:0] a, input bit [63:0] b, input bit [1:0] op, input bit sc);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_setcc = sc;
    endtask

    function automatic bit [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'd0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bit [63:0] exp_ops [4];
        bit [63:0] held;
        exp_ops[0] = 64'd75; exp_ops[1] = 64'd31; exp_ops[2] = 64'd20; exp_ops[3] = 64'd35;

        rst = 1'b1; rsp_ready = 1'b0;
        set0(1'b0, 64'd0, 64'd0, 2'b00, 1'b0);
        set1(1'b0, 64'd0, 64'd0, 2'b00, 1'b0);
        tick(); tick();
        check_val("reset_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("reset_cc", {61'd0, cc}, 64'd4);
        rst = 1'b0; rsp_ready = 1'b1;

        // all ops back-to-back on requester 1, no cc update
        for (int i = 0; i < 4; i++) begin
            set1(1'b1, 64'd53, 64'd22, i[1:0], 1'b0);
            tick();
            check_val("ops_val", rsp_val, exp_ops[i]);
            check_val("ops_cc", {61'd0, cc}, 64'd4);
        end
        set1(1'b0, 64'd0, 64'd0, 2'b00, 1'b0);

        // single issue on requester 0 with setcc
        set0(1'b1, 64'd53, 64'd22, 2'b00, 1'b1);
        tick();
        check_val("single_val", rsp_val, 64'd75);
        check_val("single_id", {63'd0, rsp_id}, 64'd0);
        check_val("single_cc", {61'd0, cc}, 64'd0);

        // overflow cases
        set0(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1);
        tick();
        check_val("ovf_add_val", rsp_val, 64'h8000_0000_0000_0000);
        check_val("ovf_add_rcc", {61'd0, rsp_cc}, 64'd3);
        check_val("ovf_add_cc", {61'd0, cc}, 64'd3);
        set0(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b1);
        tick();
        check_val("ovf_sub_cc", {61'd0, cc}, 64'd3);
        set0(1'b1, 64'd5, 64'd5, 2'b01, 1'b1);
        tick();
        check_val("zero_sub_cc", {61'd0, cc}, 64'd4);
        set0(1'b0, 64'd0, 64'd0, 2'b00, 1'b0);

        // one requester-1 op returns the pointer to 0, then contention
        set1(1'b1, 64'd1, 64'd2, 2'b00, 1'b0);
        tick();
        set0(1'b1, 64'd10, 64'd1, 2'b00, 1'b0);
        set1(1'b1, 64'd20, 64'd2, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("rr_id", {63'd0, rsp_id}, {63'd0, (i % 2) == 1});
        end
        set0(1'b0, 64'd0, 64'd0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("solo1_id", {63'd0, rsp_id}, 64'd1);
        end

        // backpressure: fire once, then stall with both requesters valid
        set1(1'b0, 64'd0, 64'd0, 2'b00, 1'b0);
        set0(1'b1, 64'd100, 64'd1, 2'b01, 1'b0);
        tick();
        held = rsp_val;
        check_val("bp_first", held, 64'd99);
        rsp_ready = 1'b0;
        set0(1'b1, 64'd7, 64'd8, 2'b00, 1'b0);
        set1(1'b1, 64'd9, 64'd9, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("bp_stable", rsp_val, held);
        end
        rsp_ready = 1'b1;
        tick();
        check_val("bp_release_valid", {63'd0, rsp_valid}, 64'd1);
        set1(1'b0, 64'd0, 64'd0, 2'b00, 1'b0);

        // reset while FULL with cc=011, request held during reset
        set0(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1);
        tick();
        check_val("pre_rst_cc", {61'd0, cc}, 64'd3);
        rst = 1'b1;
        tick();
        check_val("rst_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("rst_cc", {61'd0, cc}, 64'd4);
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            set0($urandom_range(0, 2) != 0, rnd64(), rnd64(), 2'($urandom_range(0, 3)), 1'($urandom));
            set1($urandom_range(0, 2) != 0, rnd64(), rnd64(), 2'($urandom_range(0, 3)), 1'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
